// File: rtl/trap_seq_pkg.sv
// Shared definitions for the interrupt entry/return sequencer.
// Holds the interrupt block register addresses, the sequencer state encoding and the
// default frame capacity of the interrupt block.
package trap_seq_pkg;

  // Interrupt block register map
  localparam logic [31:0] AddrImr   = 32'hffff_fffd;
  localparam logic [31:0] AddrIsr   = 32'hffff_fffe;
  localparam logic [31:0] AddrStack = 32'hffff_ffff;  // write pushes, read pops

  localparam int unsigned MaxDepthDefault = 32;

  typedef enum logic [3:0] {
    StIdle,
    StRdImr,
    StWtImr,
    StRdIsr,
    StWtIsr,
    StPush,
    StDispatch,
    StPop,
    StWtPop,
    StResume
  } state_e;

endpackage

// File: rtl/trap_seq_prio_enc32.sv
// prio_enc32: 32-bit lowest-set-bit encoder.
// Ports:
//   req_i   - request vector
//   idx_o   - index of the lowest set bit (0 when none set)
//   none_o  - high when no bit of req_i is set
module prio_enc32 (
  input  logic [31:0] req_i,
  output logic [4:0]  idx_o,
  output logic        none_o
);

  always_comb begin
    idx_o  = '0;
    none_o = (req_i == '0);
    // Scan downwards so the lowest set bit is the last to assign.
    for (int i = 31; i >= 0; i--) begin
      if (req_i[i]) begin
        idx_o = 5'(i);
      end
    end
  end

endmodule

// File: rtl/trap_seq.sv
// trap_seq: interrupt entry / return sequencer between a core and the interrupt block.
// On entry it reads IMR and ISR, pushes the return address and dispatches to the
// trampoline; on reti it pops the return address and resumes the core.
// Ports:
//   clk, reset_n            - clock, asynchronous active-low reset
//   trap, core_ready        - interrupt request level, core preemptible
//   core_pc                 - return address pushed on entry
//   reti                    - return-from-interrupt pulse
//   strobe, rw, addr, d_out - single-cycle bus access to the interrupt block
//   d_in                    - read data, valid the cycle after a read strobe
//   stall                   - holds the core while a sequence runs
//   vec_valid, vec_addr     - dispatch pulse and target
//   irq_num                 - index of the dispatched interrupt
//   ret_valid, ret_addr     - resume pulse and popped return address
//   spurious                - trap seen with nothing pending and enabled
//   overflow                - sticky: entry refused at full depth
module trap_seq
  import trap_seq_pkg::*;
#(
  parameter logic [31:0] TRAMP_BOTTOM = 32'hfffff800,
  parameter int unsigned MAX_DEPTH    = MaxDepthDefault
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        trap,
  input  logic        core_ready,
  input  logic [31:0] core_pc,
  input  logic        reti,
  output logic        strobe,
  output logic        rw,
  output logic [31:0] addr,
  output logic [31:0] d_out,
  input  logic [31:0] d_in,
  output logic        stall,
  output logic        vec_valid,
  output logic [31:0] vec_addr,
  output logic [4:0]  irq_num,
  output logic        ret_valid,
  output logic [31:0] ret_addr,
  output logic        spurious,
  output logic        overflow
);

  localparam logic [5:0] DepthLimit = 6'(MAX_DEPTH - 1);

  // Reset asserts asynchronously and releases two edges after reset_n rises.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rst_sync_q <= '0;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  state_e      state_q, state_d;
  logic [5:0]  depth_q, depth_d;
  logic [31:0] imr_q, imr_d;
  logic [4:0]  irq_q, irq_d;
  logic [31:0] ret_q, ret_d;
  logic        ovf_q, ovf_d;

  logic [31:0] pend_req;
  logic [4:0]  pend_idx;
  logic        pend_none;

  // ISR arrives on d_in while in WT_ISR and is masked by the captured IMR.
  assign pend_req = d_in & imr_q;

  prio_enc32 u_prio_enc32 (
    .req_i  (pend_req),
    .idx_o  (pend_idx),
    .none_o (pend_none)
  );

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= StIdle;
      depth_q <= '0;
      imr_q   <= '0;
      irq_q   <= '0;
      ret_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      imr_q   <= imr_d;
      irq_q   <= irq_d;
      ret_q   <= ret_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    depth_d   = depth_q;
    imr_d     = imr_q;
    irq_d     = irq_q;
    ret_d     = ret_q;
    ovf_d     = ovf_q;
    strobe    = 1'b0;
    rw        = 1'b0;
    addr      = '0;
    d_out     = '0;
    stall     = 1'b1;
    vec_valid = 1'b0;
    vec_addr  = '0;
    ret_valid = 1'b0;
    spurious  = 1'b0;

    case (state_q)
      StIdle: begin
        stall = 1'b0;
        // Gated so nothing leaks out combinationally while reset is held.
        if (rst_int_n) begin
          if (reti && (depth_q != '0)) begin
            state_d = StPop;
          end else if (trap && core_ready) begin
            if (depth_q == DepthLimit) begin
              ovf_d = 1'b1;
            end else begin
              state_d = StRdImr;
              stall   = 1'b1;
            end
          end
        end
      end
      StRdImr: begin
        strobe  = 1'b1;
        addr    = AddrImr;
        state_d = StWtImr;
      end
      StWtImr: begin
        imr_d   = d_in;
        state_d = StRdIsr;
      end
      StRdIsr: begin
        strobe  = 1'b1;
        addr    = AddrIsr;
        state_d = StWtIsr;
      end
      StWtIsr: begin
        if (pend_none) begin
          spurious = 1'b1;
          state_d  = StIdle;
        end else begin
          irq_d   = pend_idx;
          state_d = StPush;
        end
      end
      StPush: begin
        strobe  = 1'b1;
        rw      = 1'b1;
        addr    = AddrStack;
        d_out   = core_pc;
        depth_d = depth_q + 6'd1;
        state_d = StDispatch;
      end
      StDispatch: begin
        vec_valid = 1'b1;
        vec_addr  = TRAMP_BOTTOM;
        state_d   = StIdle;
      end
      StPop: begin
        strobe  = 1'b1;
        addr    = AddrStack;
        state_d = StWtPop;
      end
      StWtPop: begin
        ret_d   = d_in;
        state_d = StResume;
      end
      StResume: begin
        ret_valid = 1'b1;
        depth_d   = depth_q - 6'd1;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign irq_num  = irq_q;
  assign ret_addr = ret_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_trap_seq.sv
module tb_trap_seq;

  localparam logic [31:0] Tramp  = 32'hfffff800;
  localparam logic [31:0] AImr   = 32'hffff_fffd;
  localparam logic [31:0] AIsr   = 32'hffff_fffe;
  localparam logic [31:0] AStack = 32'hffff_ffff;
  localparam int          Full   = 31;

  logic        clk;
  logic        reset_n;
  logic        trap;
  logic        core_ready;
  logic [31:0] core_pc;
  logic        reti;
  logic        strobe;
  logic        rw;
  logic [31:0] addr;
  logic [31:0] d_out;
  logic [31:0] d_in;
  logic        stall;
  logic        vec_valid;
  logic [31:0] vec_addr;
  logic [4:0]  irq_num;
  logic        ret_valid;
  logic [31:0] ret_addr;
  logic        spurious;
  logic        overflow;

  trap_seq #(
    .TRAMP_BOTTOM (Tramp),
    .MAX_DEPTH    (32)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .trap       (trap),
    .core_ready (core_ready),
    .core_pc    (core_pc),
    .reti       (reti),
    .strobe     (strobe),
    .rw         (rw),
    .addr       (addr),
    .d_out      (d_out),
    .d_in       (d_in),
    .stall      (stall),
    .vec_valid  (vec_valid),
    .vec_addr   (vec_addr),
    .irq_num    (irq_num),
    .ret_valid  (ret_valid),
    .ret_addr   (ret_addr),
    .spurious   (spurious),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Interrupt block model: register contents and the hardware return-address stack.
  logic [31:0] imr_val, isr_val;
  logic        rd_pend;
  logic [31:0] rd_val;
  logic        prev_strobe;
  logic [31:0] slave_stack[$];
  // Reference: return addresses the core expects back, in LIFO order.
  logic [31:0] model_stack[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [31:0] v);
    for (int i = 0; i < 32; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // Observe the bus at the falling edge and schedule the read response.
  task automatic bus_observe();
    chk("no_back_to_back_strobe", 128'(strobe & prev_strobe), 128'(0));
    prev_strobe = strobe;
    rd_pend = 1'b0;
    if (strobe === 1'b1) begin
      if (rw === 1'b1) begin
        if (addr == AStack) slave_stack.push_back(d_out);
      end else begin
        rd_pend = 1'b1;
        if (addr == AImr) rd_val = imr_val;
        else if (addr == AIsr) rd_val = isr_val;
        else if (addr == AStack && slave_stack.size() > 0) rd_val = slave_stack.pop_back();
        else rd_val = $urandom();
      end
    end
  endtask

  // One clock: d_in valid for the whole cycle after a read strobe, junk otherwise.
  task automatic step();
    @(posedge clk);
    #1;
    d_in = rd_pend ? rd_val : $urandom();
    @(negedge clk);
    bus_observe();
  endtask

  task automatic do_entry(input logic [31:0] imr, input logic [31:0] isr, input logic [31:0] pc);
    logic       spur;
    int         lsb;
    logic [5:0] ec;
    logic [31:0] ea, ed, ev;
    imr_val = imr;
    isr_val = isr;
    spur = ((imr & isr) == 32'h0);
    lsb = lowest(imr & isr);
    core_pc = pc;
    core_ready = 1'b1;
    trap = 1'b1;
    #1;
    chk("entry_stall_same_cycle", 128'(stall), 128'(1));
    for (int n = 1; n <= 7; n++) begin
      step();
      if (n == 1) trap = 1'b0;
      ec[5] = (n == 1) || (n == 3) || (n == 5 && !spur);
      ec[4] = (n == 5 && !spur);
      ec[3] = spur ? (n <= 4) : (n <= 6);
      ec[2] = (n == 6 && !spur);
      ec[1] = (n == 4 && spur);
      ec[0] = 1'b0;
      ea = (n == 1) ? AImr : (n == 3) ? AIsr : (n == 5 && !spur) ? AStack : 32'h0;
      ed = (n == 5 && !spur) ? pc : 32'h0;
      ev = (n == 6 && !spur) ? Tramp : 32'h0;
      chk("entry_ctl", 128'({strobe, rw, stall, vec_valid, spurious, ret_valid}), 128'(ec));
      chk("entry_bus", 128'({addr, d_out, vec_addr}), 128'({ea, ed, ev}));
      if (n == 6 && !spur) chk("entry_irq_num", 128'(irq_num), 128'(lsb));
    end
    if (!spur) model_stack.push_back(pc);
  endtask

  task automatic do_reti(input logic with_trap);
    logic        live;
    logic [31:0] exp_ret;
    logic [5:0]  ec;
    live = (model_stack.size() > 0);
    exp_ret = live ? model_stack.pop_back() : 32'h0;
    reti = 1'b1;
    trap = with_trap;
    core_ready = 1'b1;
    #1;
    chk("reti_no_stall_same_cycle", 128'(stall), 128'(0));
    for (int n = 1; n <= 4; n++) begin
      step();
      if (n == 1) begin
        reti = 1'b0;
        trap = 1'b0;
      end
      ec = {live && n == 1, 1'b0, live && n <= 3, 1'b0, 1'b0, live && n == 3};
      chk("reti_ctl", 128'({strobe, rw, stall, vec_valid, spurious, ret_valid}), 128'(ec));
      chk("reti_addr", 128'(addr), 128'((live && n == 1) ? AStack : 32'h0));
      if (live && n == 3) chk("ret_addr", 128'(ret_addr), 128'(exp_ret));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a"}, 128'({strobe, rw, stall, vec_valid, ret_valid, spurious, overflow, irq_num,
                           addr, d_out}), 128'(0));
    chk({tag, "_b"}, 128'({vec_addr, ret_addr}), 128'(0));
  endtask

  logic [31:0] r_imr, r_isr, bit_sel;

  initial begin
    reset_n = 1'b0;
    trap = 1'b0;
    core_ready = 1'b0;
    core_pc = '0;
    reti = 1'b0;
    d_in = '0;
    rd_pend = 1'b0;
    rd_val = '0;
    prev_strobe = 1'b0;
    imr_val = '0;
    isr_val = '0;
    #12;
    chk_all_zero("reset_state");
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step();

    // Directed entry, return and double return
    do_entry(32'h0000_0014, 32'h0000_0010, 32'h0000_0100);
    do_reti(1'b0);
    do_reti(1'b0);
    // Spurious: enabled and pending do not overlap
    do_entry(32'h0000_0001, 32'h0000_0002, 32'h0000_0200);
    do_reti(1'b0);

    // Trap while core not preemptible is held off
    trap = 1'b1;
    core_ready = 1'b0;
    for (int n = 0; n < 3; n++) begin
      step();
      chk("not_ready_idle", 128'({strobe, stall}), 128'(0));
    end
    trap = 1'b0;

    // Random mix of entries and returns
    for (int k = 0; k < 12; k++) begin
      if ($urandom_range(0, 2) == 0 && model_stack.size() > 0) begin
        do_reti(1'b0);
      end else begin
        r_imr = $urandom();
        r_isr = ($urandom_range(0, 3) == 0) ? (~r_imr & $urandom()) : $urandom();
        do_entry(r_imr, r_isr, $urandom());
      end
    end

    // Fill to the refusal depth with genuine entries
    while (model_stack.size() < Full) begin
      bit_sel = 32'h1 << $urandom_range(0, 31);
      do_entry($urandom() | bit_sel, $urandom() | bit_sel, $urandom());
    end

    trap = 1'b1;
    core_ready = 1'b1;
    #1;
    chk("ovf_stall_low", 128'(stall), 128'(0));
    chk("ovf_not_yet", 128'(overflow), 128'(0));
    for (int n = 0; n < 3; n++) begin
      step();
      chk("ovf_refused", 128'({strobe, stall, overflow}), 128'(3'b001));
    end
    trap = 1'b0;
    step();
    chk("ovf_sticky", 128'(overflow), 128'(1));

    // Unwind in LIFO order down to one frame, then collide trap with reti
    while (model_stack.size() > 1) do_reti(1'b0);
    do_reti(1'b1);
    chk("collision_left_empty", 128'(model_stack.size()), 128'(0));

    // Reset in the middle of an entry (in WT_ISR)
    do_entry(32'h0000_00f0, 32'h0000_0030, 32'h0000_0abc);
    imr_val = 32'h0000_000f;
    isr_val = 32'h0000_0008;
    core_pc = 32'h0000_0def;
    trap = 1'b1;
    core_ready = 1'b1;
    step();
    trap = 1'b0;
    step();
    step();
    @(posedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk_all_zero("reset_async");
    model_stack.delete();
    slave_stack.delete();
    rd_pend = 1'b0;
    prev_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      step();
      chk("post_reset_quiet", 128'({strobe, stall}), 128'(0));
    end
    // Depth was cleared: reti must not touch the bus
    do_reti(1'b0);
    do_entry(32'h8000_0000, 32'h8000_0000, 32'h0000_1234);
    do_reti(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/trap_seq.md
TRAP_SEQ -- requirements
Module: trap_seq

Interface
REQ-001 Parameter TRAMP_BOTTOM, default 32'hfffff800, dispatch target presented to the core on interrupt entry.
REQ-002 Parameter MAX_DEPTH, default 32, number of frames the interrupt block can hold.
REQ-003 clk  in  1  single clock; all state changes on its rising edge.
REQ-004 reset_n  in  1  reset, asynchronous and active-low.
REQ-005 trap  in  1  interrupt request level from the interrupt block.
REQ-006 core_ready  in  1  core is at an instruction boundary and may be preempted.
REQ-007 core_pc  in  32  return address to push.
REQ-008 reti  in  1  one-cycle pulse: core requests return from interrupt.
REQ-009 strobe  out  1  bus access strobe.
REQ-010 rw  out  1  1 = write, 0 = read.
REQ-011 addr  out  32  bus address.
REQ-012 d_out  out  32  write data.
REQ-013 d_in  in  32  read data, valid the cycle after the read strobe.
REQ-014 stall  out  1  holds the core while a sequence runs.
REQ-015 vec_valid  out  1  one-cycle pulse: jump to vec_addr.
REQ-016 vec_addr  out  32  dispatch target.
REQ-017 irq_num  out  5  index of the dispatched interrupt.
REQ-018 ret_valid  out  1  one-cycle pulse: resume at ret_addr.
REQ-019 ret_addr  out  32  popped return address.
REQ-020 spurious  out  1  one-cycle pulse: trap seen but nothing pending and enabled.
REQ-021 overflow  out  1  sticky: entry refused because depth == MAX_DEPTH-1.

Function
REQ-022 Every bus access is a single-cycle strobe; reads capture d_in in the cycle after the strobe cycle, and strobe is never high on two consecutive cycles.
REQ-023 The register map is fixed: 0xfffffffd = IMR, 0xfffffffe = ISR, 0xffffffff = return-address stack (a write pushes, a read pops).
REQ-024 The FSM states are IDLE, RD_IMR, WT_IMR, RD_ISR, WT_ISR, PUSH, DISPATCH, POP, WT_POP, RESUME.
REQ-025 In IDLE with trap && core_ready && !overflow, the FSM goes to RD_IMR and stall is asserted in the same cycle (combinational from the transition).
REQ-026 The FSM reads IMR before the push, because a push zeroes the new frame's mask.
REQ-027 If (ISR & IMR) == 0 after WT_ISR, the FSM pulses spurious, performs no push, and returns to IDLE.
REQ-028 Otherwise irq_num is the lowest set bit index of (ISR & IMR).
REQ-029 PUSH writes core_pc to 0xffffffff and increments the internal 6-bit depth.
REQ-030 DISPATCH pulses vec_valid with vec_addr = TRAMP_BOTTOM, then the FSM goes to IDLE.
REQ-031 Entry latency from trap acceptance to vec_valid is exactly 6 cycles.
REQ-032 In IDLE, reti with depth > 0 goes to POP, which reads 0xffffffff; RESUME pulses ret_valid with the captured d_in and decrements depth; latency is 3 cycles.
REQ-033 reti with depth == 0 is ignored (no bus access); reti outside IDLE is dropped.
REQ-034 If trap and reti are both present in IDLE, reti wins.
REQ-035 If depth == MAX_DEPTH-1 when a trap would be accepted, the trap is not accepted, overflow is set, and stall stays low.
REQ-036 stall is high in every state except IDLE.
REQ-037 d_out is 0 except in PUSH.

Reset
REQ-038 Asynchronous assertion, synchronous release: FSM = IDLE; depth = 0; all outputs 0, including strobe, stall and overflow; vec_addr and ret_addr = 0.
REQ-039 Reset during a sequence abandons it immediately, with no further bus access.

Structure
REQ-040 The shared package holds the EIB register addresses, the FSM state enum and the MAX_DEPTH default.
REQ-041 One sub-module, prio_enc32 (32-bit lowest-set-bit encoder with a none-set flag), is instantiated once.

Verification
REQ-042 Entry: IMR=0x0000_0014, ISR=0x0000_0010, core_pc=0x100, trap -> reads fffffffd then fffffffe, writes 0x100 to ffffffff, vec_valid 6 cycles after acceptance, irq_num=4, vec_addr=0xfffff800.
REQ-043 Spurious: IMR=0x1, ISR=0x2 -> spurious pulse, no write strobe, depth unchanged.
REQ-044 Return: after REQ-042, reti with d_in=0x100 returned on the pop read -> ret_valid 3 cycles later, ret_addr=0x100, depth 0; a second reti -> no strobe.
REQ-045 Overflow: 31 entries, then trap -> no bus access, overflow=1, stall=0.
REQ-046 Collision and reset: trap and reti in the same IDLE cycle at depth 1 -> pop sequence first; reset_n low in WT_ISR -> all outputs 0 asynchronously, and no strobe for 2 cycles after release.
